// File: rtl/prog_loader_pkg.sv
// Shared constants for the 16-bit PU: polarity levels, instruction width,
// and the loader frame header and state encodings.
package prog_loader_pkg;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    // Instruction word MSB index; words are CMDS+1 bits wide.
    localparam int CMDS = 15;

    localparam logic [7:0] LDR_HDR = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_CNT,
        LDR_HI,
        LDR_LO,
        LDR_WR,
        LDR_SUM,
        LDR_DONE
    } ldr_state_e;

endpackage

// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a framed byte stream into 16-bit words,
// writes them from address 0 and verifies the frame's XOR checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic            im_we,
    output logic [AW-1:0]   im_addr,
    output logic [CMDS:0]   im_wd,
    output logic            pu_hold,
    output logic            done,
    output logic            err
);

    ldr_state_e     state;
    logic [7:0]     hi;
    logic [7:0]     cnt;
    logic [AW-1:0]  addr;
    logic [7:0]     acc;

    // NOTE: these outputs are pure decodes of the state register, so no
    // combinational path exists from rx_* to any output.
    assign rx_ready = (state != LDR_WR);
    assign im_we    = (state == LDR_WR);
    assign pu_hold  = (state == LDR_DONE) ? NEGATE : ASSERT;
    assign im_addr  = addr;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; reset aborts any frame but leaves memory untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LDR_IDLE;
            hi    <= '0;
            cnt   <= '0;
            addr  <= '0;
            acc   <= '0;
            im_wd <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                LDR_IDLE, LDR_DONE: begin
                    if (rx_valid && rx_data == LDR_HDR) begin
                        state <= LDR_CNT;
                        addr  <= '0;
                        acc   <= '0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                LDR_CNT: begin
                    if (rx_valid) begin
                        cnt   <= rx_data;
                        state <= (rx_data == 8'd0) ? LDR_SUM : LDR_HI;
                    end
                end
                LDR_HI: begin
                    if (rx_valid) begin
                        hi    <= rx_data;
                        acc   <= acc ^ rx_data;
                        state <= LDR_LO;
                    end
                end
                LDR_LO: begin
                    if (rx_valid) begin
                        im_wd <= {hi, rx_data};
                        acc   <= acc ^ rx_data;
                        state <= LDR_WR;
                    end
                end
                LDR_WR: begin
                    addr  <= addr + 1'b1;
                    cnt   <= cnt - 8'd1;
                    state <= (cnt == 8'd1) ? LDR_SUM : LDR_HI;
                end
                LDR_SUM: begin
                    if (rx_valid) begin
                        if (rx_data == acc) begin
                            done  <= 1'b1;
                            state <= LDR_DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= LDR_IDLE;
                        end
                    end
                end
                default: state <= LDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a frame-parsing
// reference model that predicts memory writes and done/err flags.
module tb_prog_loader;

    localparam int AW = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic           im_we;
    logic [AW-1:0]  im_addr;
    logic [15:0]    im_wd;
    logic           pu_hold;
    logic           done;
    logic           err;

    prog_loader #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wd    (im_wd),
        .pu_hold  (pu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [AW+15:0] wr_t;

    int   checks = 0;
    int   errors = 0;
    int   ready_bad = 0;
    int   max_gap = 0;
    logic m_done = 1'b0;
    logic m_err  = 1'b0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Observe every write and confirm rx_ready drops only while writing.
    always @(negedge clk) begin
        if (!rst) begin
            if (im_we) obs_q.push_back({im_addr, im_wd});
            if (rx_ready === im_we) ready_bad++;
        end
    end

    // Reference: parse complete frames positionally from the byte list.
    task automatic model_stream(input byte_q_t s);
        int i = 0;
        int n;
        logic [7:0] x;
        logic [AW-1:0] a;
        while (i < s.size()) begin
            if (s[i] != 8'hA5) begin
                i++;
                continue;
            end
            m_done = 1'b0;
            m_err  = 1'b0;
            n = int'(s[i+1]);
            i += 2;
            x = 8'h00;
            for (int w = 0; w < n; w++) begin
                a = w[AW-1:0];
                exp_q.push_back({a, s[i], s[i+1]});
                x ^= s[i] ^ s[i+1];
                i += 2;
            end
            if (s[i] == x) m_done = 1'b1;
            else           m_err  = 1'b1;
            i++;
        end
    endtask

    // Starts and ends just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        repeat ($urandom_range(0, max_gap)) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom();
    endtask

    task automatic send_all(input byte_q_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic settle_and_compare(input string tag);
        int n;
        repeat (3) @(negedge clk);
        check({tag, "_nwr"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_done"}, 32'(done), 32'(m_done));
        check({tag, "_err"},  32'(err),  32'(m_err));
        check({tag, "_hold"}, 32'(pu_hold), 32'(!m_done));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic run_stream(input string tag, input byte_q_t s);
        model_stream(s);
        send_all(s);
        settle_and_compare(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_we"},    32'(im_we),    32'd0);
        check({tag, "_addr"},  32'(im_addr),  32'd0);
        check({tag, "_wd"},    32'(im_wd),    32'd0);
        check({tag, "_hold"},  32'(pu_hold),  32'd1);
        check({tag, "_done"},  32'(done),     32'd0);
        check({tag, "_err"},   32'(err),      32'd0);
    endtask

    initial begin
        byte_q_t s;
        logic [7:0] x, b;
        int n;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst = 1'b0;
        @(negedge clk);

        run_stream("good", '{8'hA5, 8'h02, 8'h04, 8'h05, 8'h00, 8'h01, 8'h00});
        run_stream("bad",  '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h00});
        check("bad_idle_ready", 32'(rx_ready), 32'd1);

        max_gap = 4;
        run_stream("garbage", '{8'hFF, 8'h00, 8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h66});
        max_gap = 0;

        run_stream("empty", '{8'hA5, 8'h00, 8'h00});

        // Reload from DONE: hold must rise right after the header is taken.
        s = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h01};
        check("reload_pre_hold", 32'(pu_hold), 32'd0);
        model_stream(s);
        send_byte(8'hA5);
        check("reload_hold", 32'(pu_hold), 32'd1);
        check("reload_done_clr", 32'(done), 32'd0);
        for (int i = 1; i < s.size(); i++) send_byte(s[i]);
        settle_and_compare("reload");

        // Reset while the first word is about to be written.
        send_all('{8'hA5, 8'h03, 8'h11});
        rx_valid = 1'b1;
        rx_data  = 8'h22;
        @(posedge clk);
        #1 rst   = 1'b1;
        rx_valid = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst    = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        obs_q.delete();
        exp_q.delete();
        @(negedge clk);
        run_stream("after_rst", '{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'h73});

        // Longest frame at full rate.
        s = '{8'hA5, 8'hFF};
        x = 8'h00;
        for (int i = 0; i < 510; i++) begin
            b = $urandom();
            s.push_back(b);
            x ^= b;
        end
        s.push_back(x);
        run_stream("maxn", s);

        // Random frames with optional garbage, gaps and corrupted checksums.
        max_gap = 3;
        for (int f = 0; f < 20; f++) begin
            s.delete();
            repeat ($urandom_range(0, 2)) begin
                b = $urandom();
                if (b == 8'hA5) b = 8'h5A;
                s.push_back(b);
            end
            n = $urandom_range(0, 6);
            s.push_back(8'hA5);
            s.push_back(n[7:0]);
            x = 8'h00;
            for (int i = 0; i < 2 * n; i++) begin
                b = $urandom();
                s.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 3) == 0) x ^= 8'h01 << $urandom_range(0, 7);
            s.push_back(x);
            run_stream("rand", s);
        end

        check("ready_only_wr", ready_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Instruction-memory loader for the 16-bit PU. It accepts a framed byte stream over a valid/ready handshake and assembles each byte pair into a 16-bit instruction word. Each word is written into instruction memory at consecutive addresses from 0, and the frame is checked with an XOR checksum. The loader writes the instruction words that the decoder later consumes, and holds the PU (`pu_hold`) until a frame has loaded correctly.

## Interface
- `AW`, 8, instruction-memory address width in words (2^AW words).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `im_we`  out  1  instruction-memory write enable.
- `im_addr`  out  AW  instruction-memory write address.
- `im_wd`  out  `CMDS+1` (16)  instruction word to write.
- `pu_hold`  out  1  `ASSERT` keeps the PU halted with its PC held.
- `done`  out  1  level: the last frame loaded with a good checksum.
- `err`  out  1  level: the last frame failed its checksum.

## Operation
- Byte transfer occurs on any cycle where `rx_valid & rx_ready`. A byte presented while `rx_ready=0` is not consumed; the source holds it.
- Frame format: header `8'hA5`, then count N (number of words, 0..255), then 2N data bytes (high byte first), then a checksum byte.
  - The checksum is the XOR of the 2N data bytes only.
  - For N=0 the checksum is `8'h00`.
- States: IDLE, CNT, HI, LO, WR, SUM, DONE.
  - IDLE: bytes other than `A5` are discarded. On `A5`: go to CNT, clear the address counter and the XOR accumulator, and clear `done` and `err`.
  - CNT: latch N. If N=0 go to SUM, otherwise go to HI.
  - HI: latch the high byte and XOR it into the accumulator, then go to LO.
  - LO: latch the low byte and XOR it into the accumulator, then go to WR.
  - WR: `rx_ready=0`, `im_we=1`, `im_addr`=current address, `im_wd`={hi,lo}. Increment the address and decrement the remaining count. Go to SUM if the remaining count is now 0, otherwise go to HI.
  - SUM: compare the checksum byte with the accumulator.
    - Match: go to DONE with `done=1`.
    - Mismatch: go to IDLE with `err=1`.
  - DONE: `pu_hold=0`. Non-`A5` bytes are discarded. On `A5`, behave exactly as IDLE does: go to CNT and reassert `pu_hold`.
- `rx_ready=1` in every state except WR.
- `pu_hold` is asserted in every state except DONE. A failed frame leaves the PU held.
- Address arithmetic:
  - AW-bit, wraps modulo 2^AW.
  - With AW<8 and N>2^AW, later words overwrite low addresses. This is legal and not flagged.
- Reset, mid-frame or otherwise, aborts any frame and returns to IDLE. Words already written stay in memory.

## Timing
- Reset values: state IDLE, `rx_ready=1`, `im_we=0`, `im_addr=0`, `im_wd=16'h0000`, `pu_hold=1`, `done=0`, `err=0`.
- All outputs are registered or decoded from the state register only; there is no combinational path from `rx_*` to any output.
- Write latency: `im_we` is high for exactly one cycle, the cycle after the LO byte is accepted.
- Sustained rate with `rx_valid` held high: one word per 3 cycles.
- `done`/`pu_hold`/`err` update in the cycle after the checksum byte is accepted.
- `rx_valid` gaps of any length in any state only stall the state machine; accumulated state is preserved.

## Structure
- Constants go in `pu.vh` beside the existing ones:
  - `LDR_HDR` (`8'hA5`)
  - the loader state encodings
- Use `ASSERT`/`NEGATE` and `CMDS` from the same header.
- Single module with no sub-module. The datapath is just these registers:
  - hi-byte latch
  - word counter
  - address counter
  - XOR accumulator

## Test plan
- Good frame: stream `A5 02 04 05 00 01 00` → two writes: addr 0 = `0405` (LI r0,5) and addr 1 = `0001` (HALT). Then `done=1`, `pu_hold=0`, `err=0`.
- Bad checksum: stream `A5 01 12 34 00` (expected checksum `26`) → one write, addr 0 = `1234`. Then `err=1`, `pu_hold=1`, `done=0`, state IDLE.
- Garbage and backpressure: stream `FF 00 A5 01 AB CD 66` with random `rx_valid` gaps → the leading bytes are ignored, one write of `ABCD` at addr 0, `done=1`. Also check that `rx_ready=0` only during the WR cycle.
- Empty frame: stream `A5 00 00` → no writes, `done=1`, `pu_hold=0`.
- Reload after done: stream `A5 01 00 01 01` → `pu_hold` rises the cycle after `A5` is accepted, addr 0 = `0001`, `done=1` again.
- Reset mid-frame: assert `rst` after `A5 03 11 22` → all outputs return to their reset values immediately. A following good frame loads normally from addr 0.
